// File: rtl/dpram.sv
// dpram: true dual-port synchronous RAM, DEPTH x DATA_W, single clock.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset; clears outputs and every word
//   en         global enable; 0 freezes memory and both read registers
//   wr0, wr1   per-port mode: 0 = write, 1 = read
//   add0, add1 per-port word address
//   data0_in, data1_in   per-port write data
//   data0_out, data1_out per-port registered read data (one-cycle latency)
//   collision  (only with DPRAM_COLLISION_EN) one-cycle pulse after an enabled
//              same-address access in which at least one port wrote
//
// Build option: define DPRAM_COLLISION_EN to add the collision output.
//
// Semantics on a shared address: reads return the pre-edge contents
// (read-before-write), and port 0 wins a write/write conflict.
module dpram #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned DEPTH  = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              wr0,
    input  logic              wr1,
    input  logic [ADDR_W-1:0] add0,
    input  logic [ADDR_W-1:0] add1,
    input  logic [DATA_W-1:0] data0_in,
    input  logic [DATA_W-1:0] data1_in,
    output logic [DATA_W-1:0] data0_out,
`ifdef DPRAM_COLLISION_EN
    output logic [DATA_W-1:0] data1_out,
    output logic              collision
`else
    output logic [DATA_W-1:0] data1_out
`endif
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_data0;
    logic [DATA_W-1:0] r_data1;

    logic w_we0;
    logic w_we1;
    logic w_re0;
    logic w_re1;

    always_comb begin
        w_we0 = en && !wr0;
        w_we1 = en && !wr1;
        w_re0 = en && wr0;
        w_re1 = en && wr1;
    end

    // Port 1 is written first so a same-address port 0 write overrides it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_we1) begin
                r_mem[add1] <= data1_in;
            end
            if (w_we0) begin
                r_mem[add0] <= data0_in;
            end
        end
    end

    // Non-blocking reads see the pre-edge array, giving read-before-write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data0 <= '0;
            r_data1 <= '0;
        end else begin
            if (w_re0) begin
                r_data0 <= r_mem[add0];
            end
            if (w_re1) begin
                r_data1 <= r_mem[add1];
            end
        end
    end

    assign data0_out = r_data0;
    assign data1_out = r_data1;

`ifdef DPRAM_COLLISION_EN
    logic r_collision;
    logic w_collision;

    always_comb begin
        w_collision = en && (add0 == add1) && (!wr0 || !wr1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_collision <= 1'b0;
        end else begin
            r_collision <= w_collision;
        end
    end

    assign collision = r_collision;
`endif

endmodule

// File: tb/tb_dpram.sv
// tb_dpram: self-checking bench for dpram. Directed scenarios plus a random
// phase, all compared against an array model of the RAM kept in the bench.
module tb_dpram;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       wr0;
    logic       wr1;
    logic [5:0] add0;
    logic [5:0] add1;
    logic [7:0] data0_in;
    logic [7:0] data1_in;
    logic [7:0] data0_out;
    logic [7:0] data1_out;
`ifdef DPRAM_COLLISION_EN
    logic       collision;
    logic       exp_col;
`endif

    int unsigned total;
    int unsigned bad;

    logic [7:0] m [64];
    logic [7:0] exp0;
    logic [7:0] exp1;

    dpram dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .wr0       (wr0),
        .wr1       (wr1),
        .add0      (add0),
        .add1      (add1),
        .data0_in  (data0_in),
        .data1_in  (data1_in),
        .data0_out (data0_out),
`ifdef DPRAM_COLLISION_EN
        .data1_out (data1_out),
        .collision (collision)
`else
        .data1_out (data1_out)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 64; i++) m[i] = 8'h00;
        exp0 = 8'h00;
        exp1 = 8'h00;
`ifdef DPRAM_COLLISION_EN
        exp_col = 1'b0;
`endif
    endtask

    // One clock of stimulus: drive at negedge, apply the model at the edge,
    // compare 1 time unit after the edge.
    task automatic step(input string tag, input logic e, input logic w0, input logic w1,
                        input logic [5:0] a0, input logic [5:0] a1,
                        input logic [7:0] d0, input logic [7:0] d1);
        @(negedge clk);
        en = e; wr0 = w0; wr1 = w1; add0 = a0; add1 = a1; data0_in = d0; data1_in = d1;
        @(posedge clk);
        if (e) begin
            if (w0) exp0 = m[a0];
            if (w1) exp1 = m[a1];
            if (!w1) m[a1] = d1;
            if (!w0) m[a0] = d0;
        end
`ifdef DPRAM_COLLISION_EN
        exp_col = e && (a0 == a1) && (!w0 || !w1);
`endif
        #1;
        check({tag, "_p0"}, data0_out, exp0);
        check({tag, "_p1"}, data1_out, exp1);
`ifdef DPRAM_COLLISION_EN
        check({tag, "_col"}, {7'b0, collision}, {7'b0, exp_col});
`endif
    endtask

    logic [7:0] vals [8];
    logic [7:0] held0;
    logic [7:0] held1;
    logic [5:0] ra0;
    logic [5:0] ra1;

    initial begin
        total = 0;
        bad = 0;
        vals[0] = 8'h24; vals[1] = 8'h81; vals[2] = 8'h09; vals[3] = 8'h63;
        vals[4] = 8'h0D; vals[5] = 8'h8D; vals[6] = 8'h65; vals[7] = 8'h12;
        en = 0; wr0 = 1; wr1 = 1; add0 = 0; add1 = 0; data0_in = 0; data1_in = 0;
        model_clear();

        // Reset held for two cycles, then released at a falling edge.
        rst_n = 1'b0;
        #1;
        check("rst_p0", data0_out, 8'h00);
        check("rst_p1", data1_out, 8'h00);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int a = 0; a < 64; a++) begin
            step("rd_init", 1, 1, 1, 6'(a), 6'(63 - a), 8'h00, 8'h00);
        end

        // Port 0 writes 0..7 while port 1 reads a far address.
        for (int a = 0; a < 8; a++) begin
            step("wr8", 1, 0, 1, 6'(a), 6'd63, vals[a], 8'h00);
        end
        for (int a = 0; a < 8; a++) begin
            step("rd8", 1, 1, 1, 6'd40, 6'(a), 8'h00, 8'h00);
            check("rd8_const", data1_out, vals[a]);
        end

        // Enable gating: write attempt and read attempts ignored, outputs held.
        step("pre_gate", 1, 1, 1, 6'd2, 6'd7, 8'h00, 8'h00);
        held0 = data0_out;
        held1 = data1_out;
        step("gate_w", 0, 0, 0, 6'd5, 6'd5, 8'hFF, 8'hFF);
        check("gate_hold0", data0_out, held0);
        check("gate_hold1", data1_out, held1);
        step("gate_r", 0, 1, 1, 6'd0, 6'd1, 8'h00, 8'h00);
        check("gate_hold1b", data1_out, held1);
        step("gate_rd5", 1, 1, 1, 6'd5, 6'd5, 8'h00, 8'h00);
        check("gate_rd5_const", data0_out, 8'h8D);

        // Same-address collisions.
        step("col_ww", 1, 0, 0, 6'd10, 6'd10, 8'hAA, 8'h55);
        step("col_ww_rd", 1, 1, 1, 6'd10, 6'd10, 8'h00, 8'h00);
        check("col_ww_const", data1_out, 8'hAA);
        step("col_wr", 1, 0, 1, 6'd10, 6'd10, 8'h3C, 8'h00);
        check("col_wr_old", data1_out, 8'hAA);
        step("col_wr_next", 1, 1, 1, 6'd11, 6'd10, 8'h00, 8'h00);
        check("col_wr_new", data1_out, 8'h3C);
        step("col_rw", 1, 1, 0, 6'd12, 6'd12, 8'h00, 8'h77);
        check("col_rw_old", data0_out, 8'h00);
        step("col_rw_next", 1, 1, 1, 6'd12, 6'd3, 8'h00, 8'h00);
        check("col_rw_new", data0_out, 8'h77);

        // Random phase; addresses often forced equal to provoke collisions.
        for (int n = 0; n < 400; n++) begin
            ra0 = 6'($urandom_range(0, 63));
            ra1 = ($urandom_range(0, 2) == 0) ? ra0 : 6'($urandom_range(0, 63));
            step("rand", ($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom),
                 ra0, ra1, 8'($urandom), 8'($urandom));
        end

        // Make both outputs nonzero, then reset in the middle of a write burst.
        step("pre_rst_w", 1, 0, 0, 6'd20, 6'd21, 8'h5A, 8'hC3);
        step("pre_rst_r", 1, 1, 1, 6'd20, 6'd21, 8'h00, 8'h00);
        check("pre_rst_const", data0_out, 8'h5A);
        step("burst", 1, 0, 0, 6'd30, 6'd31, 8'h11, 8'h22);
        @(negedge clk);
        wr0 = 0; wr1 = 0; add0 = 6'd32; add1 = 6'd33; data0_in = 8'h99; data1_in = 8'h98;
        #2;
        rst_n = 1'b0;
        model_clear();
        #1;
        check("arst_p0", data0_out, 8'h00);
        check("arst_p1", data1_out, 8'h00);
`ifdef DPRAM_COLLISION_EN
        check("arst_col", {7'b0, collision}, 8'h00);
`endif
        @(posedge clk);
        @(negedge clk);
        en = 1'b0;
        rst_n = 1'b1;
        for (int a = 0; a < 64; a++) begin
            step("rd_post_rst", 1, 1, 1, 6'(a), 6'(63 - a), 8'h00, 8'h00);
            check("rd_post_rst_const", data0_out, 8'h00);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
